// File: rtl/prbs_tx_gen_if.sv
// Word-strobe control and data bus of the PRBS link-test transmitter.
// The generator drives the data side (master); the consumer uses the slave modport.
interface prbs_tx_gen_if #(
    parameter int DATA_W = 48
);
    logic              OUT_CLK_ENA;
    logic              START;
    logic [1:0]        MODE;
    logic              INJ_ERR;
    logic [DATA_W-1:0] PRBS;
    logic              DATA_VALID;
    logic              STRT_LTNCY;
    logic [31:0]       WORD_CNT;
    logic [15:0]       ERR_CNT;

    modport master (
        input  OUT_CLK_ENA, START, MODE, INJ_ERR,
        output PRBS, DATA_VALID, STRT_LTNCY, WORD_CNT, ERR_CNT
    );

    modport slave (
        output OUT_CLK_ENA, START, MODE, INJ_ERR,
        input  PRBS, DATA_VALID, STRT_LTNCY, WORD_CNT, ERR_CNT
    );
endinterface

// File: rtl/prbs_tx_gen.sv
// Preamble + PRBS7/15/23/31 word generator with word counter; define PRBS_TX_INJ_EN
// to build the one-shot error-injection path and its saturating ERR_CNT.
module prbs_tx_gen #(
    parameter int                DATA_W        = 48,
    parameter int                PREAMBLE_LEN  = 2,
    parameter logic [DATA_W-1:0] START_PATTERN = DATA_W'({{(DATA_W/2){1'b1}}, {(DATA_W/2){1'b0}}}),
    parameter logic [DATA_W-1:0] ERR_MASK      = DATA_W'(48'h608000400100)
) (
    input  logic          GEN_CLK,
    input  logic          RST_N,
    prbs_tx_gen_if.master bus
);
    localparam logic [7:0] PRE_LEN = 8'(PREAMBLE_LEN);

    typedef enum logic [1:0] {IDLE, PREAMBLE, RUN} state_t;

    typedef struct packed {
        logic [30:0]       lfsr;
        logic [DATA_W-1:0] word;
    } step_t;

    function automatic logic [30:0] seed_of(input logic [1:0] m);
        case (m)
            2'b00:   return 31'h0000_007F;
            2'b01:   return 31'h0000_7FFF;
            2'b10:   return 31'h007F_FFFF;
            default: return 31'h7FFF_FFFF;
        endcase
    endfunction

    // Unrolls DATA_W Fibonacci steps; the first feedback bit lands in the word MSB.
    function automatic step_t lfsr_step(input logic [30:0] seed, input logic [1:0] m);
        step_t r;
        logic [30:0] l;
        logic        fb;
        l      = seed;
        r.word = '0;
        for (int i = 0; i < DATA_W; i++) begin
            case (m)
                2'b00:   fb = l[6]  ^ l[5];
                2'b01:   fb = l[14] ^ l[13];
                2'b10:   fb = l[22] ^ l[17];
                default: fb = l[30] ^ l[27];
            endcase
            l                   = {l[29:0], fb};
            r.word[DATA_W-1-i]  = fb;
        end
        r.lfsr = l;
        return r;
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [30:0]       lfsr_q, lfsr_d;
    logic [7:0]        pre_cnt_q, pre_cnt_d;
    logic [DATA_W-1:0] prbs_q, prbs_d;
    logic              valid_q, valid_d;
    logic              strt_q, strt_d;
    logic [31:0]       word_cnt_q, word_cnt_d, word_base;
    logic              emit, start_load, inj_armed;
    step_t             step;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_d    = state_q;
        mode_d     = mode_q;
        lfsr_d     = lfsr_q;
        pre_cnt_d  = pre_cnt_q;
        prbs_d     = prbs_q;
        valid_d    = valid_q;
        strt_d     = 1'b0;
        word_cnt_d = word_cnt_q;
        emit       = 1'b0;
        start_load = 1'b0;
        // From IDLE the first word (zero-length preamble) comes straight from the new seed.
        if (state_q == IDLE) step = lfsr_step(seed_of(bus.MODE), bus.MODE);
        else                 step = lfsr_step(lfsr_q, mode_q);

        if (!bus.START) begin
            state_d = IDLE;
            prbs_d  = '0;
            valid_d = 1'b0;
        end else if (bus.OUT_CLK_ENA) begin
            case (state_q)
                IDLE: begin
                    mode_d     = bus.MODE;
                    lfsr_d     = seed_of(bus.MODE);
                    start_load = 1'b1;
                    word_cnt_d = '0;
                    valid_d    = 1'b1;
                    if (PRE_LEN == 8'd0) begin
                        emit    = 1'b1;
                        state_d = RUN;
                    end else begin
                        prbs_d    = START_PATTERN;
                        pre_cnt_d = 8'd1;
                        state_d   = PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    if (pre_cnt_q != PRE_LEN) begin
                        prbs_d    = START_PATTERN;
                        pre_cnt_d = pre_cnt_q + 8'd1;
                    end else begin
                        emit    = 1'b1;
                        state_d = RUN;
                    end
                end
                RUN:     emit    = 1'b1;
                default: state_d = IDLE;
            endcase
        end

        word_base = start_load ? '0 : word_cnt_q;
        if (emit) begin
            lfsr_d     = step.lfsr;
            prbs_d     = step.word ^ (inj_armed ? ERR_MASK : '0);
            valid_d    = 1'b1;
            strt_d     = (state_q != RUN);
            word_cnt_d = (word_base == 32'hFFFF_FFFF) ? word_base : word_base + 32'd1;
        end
    end

    always_ff @(posedge GEN_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            mode_q     <= 2'b00;
            lfsr_q     <= '0;
            pre_cnt_q  <= '0;
            prbs_q     <= '0;
            valid_q    <= 1'b0;
            strt_q     <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all registers update together.
            state_q    <= state_d;
            mode_q     <= mode_d;
            lfsr_q     <= lfsr_d;
            pre_cnt_q  <= pre_cnt_d;
            prbs_q     <= prbs_d;
            valid_q    <= valid_d;
            strt_q     <= strt_d;
            word_cnt_q <= word_cnt_d;
        end
    end

`ifdef PRBS_TX_INJ_EN
    logic        pending_q;
    logic [15:0] err_cnt_q, err_cnt_d;

    assign inj_armed = pending_q;

    always_comb begin
        err_cnt_d = start_load ? '0 : err_cnt_q;
        if (emit && pending_q && err_cnt_d != 16'hFFFF) err_cnt_d = err_cnt_d + 16'd1;
    end

    // The applying word consumes the request; a pulse on that same edge does not re-arm.
    always_ff @(posedge GEN_CLK or negedge RST_N) begin
        if (!RST_N) begin
            pending_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            if (!bus.START)              pending_q <= 1'b0;
            else if (emit && pending_q)  pending_q <= 1'b0;
            else if (bus.INJ_ERR)        pending_q <= 1'b1;
        end
    end

    assign bus.ERR_CNT = err_cnt_q;
`else
    logic unused_inj;
    assign unused_inj  = bus.INJ_ERR;
    assign inj_armed   = 1'b0;
    assign bus.ERR_CNT = '0;
`endif

    assign bus.PRBS       = prbs_q;
    assign bus.DATA_VALID = valid_q;
    assign bus.STRT_LTNCY = strt_q;
    assign bus.WORD_CNT   = word_cnt_q;
endmodule

// File: tb/tb_prbs_tx_gen.sv
// Directed bench for prbs_tx_gen: 8/16/48-bit instances, hand-computed words plus a
// history-based PRBS model; injection expectations follow PRBS_TX_INJ_EN.
module tb_prbs_tx_gen;
    logic clk;
    logic rst_n;

    prbs_tx_gen_if #(.DATA_W(8))  if8 ();
    prbs_tx_gen_if #(.DATA_W(16)) if16 ();
    prbs_tx_gen_if #(.DATA_W(48)) if48 ();

    prbs_tx_gen #(.DATA_W(8), .PREAMBLE_LEN(2)) dut8 (
        .GEN_CLK(clk), .RST_N(rst_n), .bus(if8)
    );
    prbs_tx_gen #(.DATA_W(16), .PREAMBLE_LEN(0)) dut16 (
        .GEN_CLK(clk), .RST_N(rst_n), .bus(if16)
    );
    prbs_tx_gen #(.DATA_W(48), .PREAMBLE_LEN(2)) dut48 (
        .GEN_CLK(clk), .RST_N(rst_n), .bus(if48)
    );

    localparam logic [63:0] MASK48 = 64'h0000_6080_0040_0100;
    localparam logic [63:0] PAT48  = 64'h0000_FFFF_FF00_0000;

    int n_cmp = 0;
    int n_bad = 0;

    bit hist[$];
    int tap_a;
    int tap_b;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: s[n] = s[n-tA] ^ s[n-tB], with the previous tA bits all ones at start.
    task automatic model_init(input int mode);
        hist.delete();
        case (mode)
            0:       begin tap_a = 7;  tap_b = 6;  end
            1:       begin tap_a = 15; tap_b = 14; end
            2:       begin tap_a = 23; tap_b = 18; end
            default: begin tap_a = 31; tap_b = 28; end
        endcase
        for (int i = 0; i < tap_a; i++) hist.push_back(1'b1);
    endtask

    task automatic model_word(input int w, output logic [63:0] word);
        bit b;
        word = '0;
        for (int i = 0; i < w; i++) begin
            b = hist[hist.size() - tap_a] ^ hist[hist.size() - tap_b];
            hist.push_back(b);
            if (hist.size() > 40) void'(hist.pop_front());
            word = {word[62:0], b};
        end
    endtask

    initial begin
        logic [63:0] exp;
        logic [63:0] skip;

        rst_n = 1'b0;
        if8.OUT_CLK_ENA  = 1'b0; if8.START  = 1'b0; if8.MODE  = 2'b00; if8.INJ_ERR  = 1'b0;
        if16.OUT_CLK_ENA = 1'b0; if16.START = 1'b0; if16.MODE = 2'b00; if16.INJ_ERR = 1'b0;
        if48.OUT_CLK_ENA = 1'b0; if48.START = 1'b0; if48.MODE = 2'b00; if48.INJ_ERR = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_prbs",  64'(if48.PRBS),       64'h0);
        check("rst_valid", 64'(if48.DATA_VALID), 64'h0);
        check("rst_strt",  64'(if48.STRT_LTNCY), 64'h0);
        check("rst_wcnt",  64'(if48.WORD_CNT),   64'h0);
        check("rst_ecnt",  64'(if48.ERR_CNT),    64'h0);
        rst_n = 1'b1;
        tick();

        // PRBS7, 8-bit words, two-word preamble
        if8.MODE = 2'b00; if8.START = 1'b1; if8.OUT_CLK_ENA = 1'b1;
        tick();
        check("p7_pre0",  64'(if8.PRBS),       64'hF0);
        check("p7_val0",  64'(if8.DATA_VALID), 64'h1);
        check("p7_strt0", 64'(if8.STRT_LTNCY), 64'h0);
        tick();
        check("p7_pre1",  64'(if8.PRBS),       64'hF0);
        tick();
        check("p7_w1",    64'(if8.PRBS),       64'h02);
        check("p7_strt1", 64'(if8.STRT_LTNCY), 64'h1);
        check("p7_cnt1",  64'(if8.WORD_CNT),   64'd1);
        tick();
        check("p7_w2",    64'(if8.PRBS),       64'h0C);
        check("p7_strt2", 64'(if8.STRT_LTNCY), 64'h0);
        tick();
        check("p7_w3",    64'(if8.PRBS),       64'h28);
        check("p7_cnt3",  64'(if8.WORD_CNT),   64'd3);
        if8.OUT_CLK_ENA = 1'b0;
        tick();
        check("p7_hold",  64'(if8.PRBS),       64'h28);
        check("p7_hcnt",  64'(if8.WORD_CNT),   64'd3);

        // MODE change mid-run must not alter the polynomial
        model_init(0);
        repeat (3) model_word(8, skip);
        model_word(8, exp);
        if8.MODE = 2'b11; if8.OUT_CLK_ENA = 1'b1;
        tick();
        check("p7_modeign", 64'(if8.PRBS), exp);

        // START drop without enable, then restart from seed
        if8.START = 1'b0; if8.OUT_CLK_ENA = 1'b0;
        tick();
        check("drop_prbs",  64'(if8.PRBS),       64'h0);
        check("drop_valid", 64'(if8.DATA_VALID), 64'h0);
        check("drop_wcnt",  64'(if8.WORD_CNT),   64'd4);
        if8.MODE = 2'b00; if8.START = 1'b1; if8.OUT_CLK_ENA = 1'b1;
        tick();
        check("rs_pre0", 64'(if8.PRBS),     64'hF0);
        check("rs_wcnt", 64'(if8.WORD_CNT), 64'd0);
        tick();
        check("rs_pre1", 64'(if8.PRBS),     64'hF0);
        tick();
        check("rs_w1",   64'(if8.PRBS),       64'h02);
        check("rs_strt", 64'(if8.STRT_LTNCY), 64'h1);
        check("rs_cnt1", 64'(if8.WORD_CNT),   64'd1);
        if8.START = 1'b0;

        // PRBS15, 16-bit words, no preamble: first word on the START edge
        if16.MODE = 2'b01; if16.START = 1'b1; if16.OUT_CLK_ENA = 1'b1;
        tick();
        check("p15_w1",   64'(if16.PRBS),       64'h0002);
        check("p15_strt", 64'(if16.STRT_LTNCY), 64'h1);
        check("p15_val",  64'(if16.DATA_VALID), 64'h1);
        check("p15_cnt1", 64'(if16.WORD_CNT),   64'd1);
        tick();
        check("p15_w2",   64'(if16.PRBS),       64'h000C);
        check("p15_cnt2", 64'(if16.WORD_CNT),   64'd2);
        if16.START = 1'b0;

        // PRBS31, 48-bit words, 1000 words with the strobe toggling
        model_init(3);
        if48.MODE = 2'b11; if48.START = 1'b1; if48.OUT_CLK_ENA = 1'b1;
        tick();
        check("p31_pre0", 64'(if48.PRBS), PAT48);
        tick();
        check("p31_pre1", 64'(if48.PRBS), PAT48);
        tick();
        model_word(48, skip);
        check("p31_w1",   64'(if48.PRBS),       64'h0000_0000_000E_0000);
        check("p31_strt", 64'(if48.STRT_LTNCY), 64'h1);
        for (int i = 0; i < 999; i++) begin
            if48.OUT_CLK_ENA = 1'b1;
            tick();
            model_word(48, exp);
            check("p31_word", 64'(if48.PRBS), exp);
            if48.OUT_CLK_ENA = 1'b0;
            tick();
            check("p31_hold", 64'(if48.PRBS), exp);
        end
        check("p31_cnt", 64'(if48.WORD_CNT), 64'd1000);

        // Three injection requests while the strobe is low collapse to one injected word
        for (int i = 0; i < 3; i++) begin
            if48.INJ_ERR = 1'b1;
            tick();
            if48.INJ_ERR = 1'b0;
            tick();
        end
        check("inj_idlehold", 64'(if48.PRBS), exp);
        if48.OUT_CLK_ENA = 1'b1;
        tick();
        model_word(48, exp);
`ifdef PRBS_TX_INJ_EN
        check("inj_word", 64'(if48.PRBS),    exp ^ MASK48);
        check("inj_ecnt", 64'(if48.ERR_CNT), 64'd1);
`else
        check("inj_word", 64'(if48.PRBS),    exp);
        check("inj_ecnt", 64'(if48.ERR_CNT), 64'd0);
`endif
        tick();
        model_word(48, exp);
        check("inj_next",  64'(if48.PRBS),     exp);
        check("inj_wcnt",  64'(if48.WORD_CNT), 64'd1002);
`ifdef PRBS_TX_INJ_EN
        check("inj_ecnt2", 64'(if48.ERR_CNT),  64'd1);
`else
        check("inj_ecnt2", 64'(if48.ERR_CNT),  64'd0);
`endif

        // Asynchronous reset between edges clears outputs at once
        tick();
        model_word(48, exp);
        check("ar_pre", 64'(if48.PRBS), exp);
        #3 rst_n = 1'b0;
        #1;
        check("ar_prbs",  64'(if48.PRBS),       64'h0);
        check("ar_valid", 64'(if48.DATA_VALID), 64'h0);
        check("ar_wcnt",  64'(if48.WORD_CNT),   64'h0);
        check("ar_ecnt",  64'(if48.ERR_CNT),    64'h0);
        #2 rst_n = 1'b1;
        tick();
        check("ar_pre0",  64'(if48.PRBS), PAT48);
        tick();
        check("ar_pre1",  64'(if48.PRBS), PAT48);
        tick();
        check("ar_w1",    64'(if48.PRBS),       64'h0000_0000_000E_0000);
        check("ar_strt",  64'(if48.STRT_LTNCY), 64'h1);
        check("ar_cnt1",  64'(if48.WORD_CNT),   64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prbs_tx_gen.md
# prbs_tx_gen

Parametrised PRBS word generator for the transmit side of link tests: the successor to the fixed 48-bit, single-polynomial transmitter. It emits a programmable-length start-pattern preamble, then a continuous PRBS7/15/23/31 stream at a run-time selected polynomial, advancing DATA_W bits per enabled clock. It adds one-shot error injection with a saturating injected-error counter and a word counter for the downstream checker and latency measurement.

## Interface
- DATA_W, 48: output word width, 8..64.
- PREAMBLE_LEN, 2: number of start-pattern words before PRBS data, 0..255.
- START_PATTERN, {DATA_W/2 ones, DATA_W/2 zeros}: preamble word.
- ERR_MASK, 48'h608000400100 (zero-extended or truncated to DATA_W): XOR mask for injected words.

- GEN_CLK  in  1  sole clock; all state on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- OUT_CLK_ENA  in  1  word strobe; state and data advance only on edges where high.
- START  in  1  level; high = run, low = return to IDLE.
- MODE  in  2  polynomial: 00 PRBS7 (taps 7,6), 01 PRBS15 (15,14), 10 PRBS23 (23,18), 11 PRBS31 (31,28).
- INJ_ERR  in  1  pulse; requests error injection on the next RUN word.
- PRBS  out  DATA_W  output word, MSB = earliest sequence bit.
- DATA_VALID  out  1  high while PRBS carries preamble or PRBS data.
- STRT_LTNCY  out  1  one-GEN_CLK-cycle pulse with the first PRBS data word.
- WORD_CNT  out  32  PRBS data words emitted since last preamble, saturating.
- ERR_CNT  out  16  injected words since last preamble, saturating.

## Operation
- States: IDLE, PREAMBLE, RUN. Reset to IDLE.
- IDLE: PRBS=0, DATA_VALID=0. On enabled edge with START=1: latch MODE, load LFSR seed (low N bits all ones, N=polynomial degree), clear WORD_CNT/ERR_CNT, go PREAMBLE (or RUN directly if PREAMBLE_LEN=0).
- PREAMBLE: PRBS=START_PATTERN, DATA_VALID=1; preamble counter counts enabled edges; after PREAMBLE_LEN words go RUN.
- RUN: each enabled edge outputs next DATA_W sequence bits, DATA_VALID=1, WORD_CNT+1 (holds at 32'hFFFFFFFF).
- START=0 on any edge (enable not required): IDLE next edge, PRBS=0, counters hold, pending injection cleared.
- MODE changes outside IDLE ignored until next START.
- LFSR, 31 bits, Fibonacci; per bit: fb = L[tA-1]^L[tB-1]; L = {L[29:0],fb}; output bit = fb. DATA_W bits computed in parallel per enabled edge.
- Injection: INJ_ERR high on any edge (enable irrelevant) sets pending flag. Next RUN word is PRBS^ERR_MASK, clears pending, ERR_CNT+1 (holds at 16'hFFFF). Multiple pulses before application collapse to one. INJ_ERR high on the applying edge is consumed by that word (no re-arm). LFSR sequence itself is never corrupted.

## Timing
- Reset values: PRBS=0, DATA_VALID=0, STRT_LTNCY=0, WORD_CNT=0, ERR_CNT=0, state IDLE, pending=0.
- All outputs registered; held between enabled edges except STRT_LTNCY.
- START sampled high at enabled edge k -> first preamble word at edge k; first PRBS word at enabled edge k+PREAMBLE_LEN with STRT_LTNCY=1 for that one GEN_CLK cycle only.
- Reset asserted mid-run: outputs to reset values immediately; restart requires START with a fresh preamble.

## Configuration
- PRBS_TX_INJ_EN defined: injection path, pending flag and ERR_CNT as above.
- Undefined: INJ_ERR ignored, no XOR path, ERR_CNT tied to 0; all else identical.

## Test plan
- DATA_W=8, PREAMBLE_LEN=2, MODE=00, START high -> PRBS 8'hF0, 8'hF0, then 8'h02 with STRT_LTNCY one cycle, WORD_CNT=1.
- MODE=11, DATA_W=48, 1000 words fed to a reference PRBS31 model -> zero mismatches; OUT_CLK_ENA toggled 1/0 -> PRBS changes only on enabled edges.
- INJ_ERR pulsed 3 times while OUT_CLK_ENA low, then one RUN word -> exactly one word equals expected^48'h608000400100, ERR_CNT=1, following word clean.
- START dropped mid-RUN then reasserted -> PRBS=0 next edge, new preamble, WORD_CNT restarts from 0, sequence restarts at seed.
- RST_N low mid-RUN (asynchronous to GEN_CLK) -> all outputs zero without waiting for an edge.
- Build without PRBS_TX_INJ_EN, pulse INJ_ERR -> stream identical to model, ERR_CNT=0.
